// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers per-bit propagate/generate, the carry-in and the operand
// sign bits. Stage 2 resolves carries through a chain of 2-bit lookahead
// groups and registers the sum and flags. Valid/ready on both sides, one
// operation per cycle when the consumer is ready.

// 2-bit propagate/generate carry unit: produces the carries into bit 1 and
// out of bit 1 of a group from the group's p/g pair and its carry-in.
module cla_pg2 (
    input  logic [1:0] p,
    input  logic [1:0] g,
    input  logic       ci,
    output logic       c1,
    output logic       c2
);

    // Two-level lookahead for both carries of the group.
    always_comb begin
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    end

endmodule

module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NGRP = WIDTH / 2;

    // Pipeline control
    logic adv1;
    logic adv2;
    logic accept;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             c0_q, c0_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;

    // Stage 2 (result) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Operand conditioning
    logic [WIDTH-1:0] bb;
    logic             c0_in;

    // Carry chain: carry[i] is the carry into bit i, carry[WIDTH] the carry out
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    // Handshake: a stage advances when its downstream slot is empty or draining
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        accept   = in_valid && adv1;
        in_ready = adv1;
    end

    // Invert B and force the carry-in for subtraction
    always_comb begin
        bb    = sub ? ~b : b;
        c0_in = sub ? 1'b1 : cin;
    end

    // Stage 1 next state: load p/g on accept, hold while stalled
    always_comb begin
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        c0_d       = c0_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        if (adv1) begin
            s1_valid_d = accept;
            if (accept) begin
                p_d  = a ^ bb;
                g_d  = a & bb;
                c0_d = c0_in;
                sa_d = a[WIDTH-1];
                sb_d = bb[WIDTH-1];
            end
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            c0_q       <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            g_q        <= g_d;
            c0_q       <= c0_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
        end
    end

    assign carry[0] = c0_q;

    // Lookahead groups rippling group-to-group
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_pg2 u_pg2 (
            .p  (p_q[2*k+1:2*k]),
            .g  (g_q[2*k+1:2*k]),
            .ci (carry[2*k]),
            .c1 (carry[2*k+1]),
            .c2 (carry[2*k+2])
        );
    end

    // Stage 2 next state: sum and flags load only when a valid beat moves up
    always_comb begin
        sum_c       = p_q ^ carry[WIDTH-1:0];
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = sum_c;
                cout_d = carry[WIDTH];
                // Equivalent to carry[WIDTH] ^ carry[WIDTH-1]: operands of equal
                // sign whose sum sign differs.
                ovf_d  = (sa_q ~^ sb_q) & (sum_c[WIDTH-1] ^ sa_q);
                zero_d = ~|sum_c;
            end
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: a 32-bit instance for the datapath and
// handshake scenarios, a 2-bit instance for an exhaustive group sweep.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, sub, cin, out_valid, out_ready;
    logic        cout, ovf, zero;
    logic [31:0] a, b, sum;

    logic        in_valid2, in_ready2, sub2, cin2, out_valid2, out_ready2;
    logic        cout2, ovf2, zero2;
    logic [1:0]  a2, b2, sum2;

    int total = 0;
    int bad   = 0;

    cla_pipe_adder #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    cla_pipe_adder #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .sub       (sub2),
        .cin       (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2),
        .ovf       (ovf2),
        .zero      (zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat for exactly one clock edge, then withdraw it.
    task automatic drive_beat(input logic [31:0] va, input logic [31:0] vb,
                              input logic vsub, input logic vcin);
        @(posedge clk); #1;
        in_valid = 1'b1; a = va; b = vb; sub = vsub; cin = vcin;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({out_valid, sum, cout, ovf, zero} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got v=%0b sum=%h c=%0b o=%0b z=%0b exp all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
    endtask

    task automatic test_add_basic();
        out_ready = 1'b1;
        drive_beat(32'h5, 32'h3, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_latency1 out_valid got %0b exp 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 32'h8, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_5_3 got v=%0b sum=%h c=%0b o=%0b z=%0b exp v=1 sum=00000008 c=0 o=0 z=0",
                     out_valid, sum, cout, ovf, zero);
        end
    endtask

    task automatic test_full_carry();
        out_ready = 1'b1;
        drive_beat(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({out_valid, sum, cout, ovf, zero} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL full_carry got v=%0b sum=%h c=%0b o=%0b z=%0b exp v=1 sum=00000000 c=1 o=0 z=1",
                     out_valid, sum, cout, ovf, zero);
        end
    endtask

    task automatic test_overflow_sub();
        // a, b, sub, cin, expected sum, cout, ovf, zero
        logic [31:0] ta [5] = '{32'h7FFF_FFFF, 32'h5, 32'h7, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] tb [5] = '{32'h1, 32'h7, 32'h7, 32'h1, 32'h0000_1111};
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] es [5] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h0, 32'h7FFF_FFFF, 32'h1234_4567};
        logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        eo [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(ta[i], tb[i], ts[i], tc[i]);
            @(posedge clk); #1;
            total++;
            if ({out_valid, sum, cout, ovf, zero} !== {1'b1, es[i], ec[i], eo[i], ez[i]}) begin
                bad++;
                $display("FAIL ovf_sub[%0d] got v=%0b sum=%h c=%0b o=%0b z=%0b exp v=1 sum=%h c=%0b o=%0b z=%0b",
                         i, out_valid, sum, cout, ovf, zero, es[i], ec[i], eo[i], ez[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
        logic [31:0] vb [4] = '{32'd7, 32'd8, 32'd9, 32'd10};
        logic [31:0] es [4] = '{32'd107, 32'd208, 32'd309, 32'd410};
        int unsigned tx   = 0;
        int unsigned rx   = 0;
        int unsigned held = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            in_valid = (tx < 4);
            if (tx < 4) begin
                a = va[tx]; b = vb[tx];
            end
            sub = 1'b0; cin = 1'b0;
            out_ready = (held >= 3);
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (sum !== es[0]) begin
                    bad++;
                    $display("FAIL stall_stable got %h exp %h", sum, es[0]);
                end
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready got %0b exp 0", in_ready);
                end
                held++;
            end
            if (out_ready) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL drain_in_ready got %0b exp 1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sum !== es[rx]) begin
                    bad++;
                    $display("FAIL order[%0d] got %h exp %h", rx, sum, es[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (rx != 4 || held != 3) begin
            bad++;
            $display("FAIL b2b_count got rx=%0d held=%0d exp rx=4 held=3", rx, held);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_dup out_valid got %0b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'h100; b = 32'h23; sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        a = 32'h200; b = 32'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, sum} !== {1'b1, 32'h123}) begin
            bad++;
            $display("FAIL pre_reset got v=%0b sum=%h exp v=1 sum=00000123", out_valid, sum);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sum, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset got v=%0b sum=%h rdy=%0b exp v=0 sum=00000000 rdy=1",
                     out_valid, sum, in_ready);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 32'h1; b = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_lat1 out_valid got %0b exp 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, sum} !== {1'b1, 32'h2}) begin
            bad++;
            $display("FAIL post_reset_sum got v=%0b sum=%h exp v=1 sum=00000002", out_valid, sum);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_flush out_valid got %0b exp 0", out_valid);
        end
    endtask

    task automatic test_exhaustive_w2();
        logic [1:0] bbv;
        logic [2:0] tot;
        logic       ov;
        out_ready2 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4]; sub2 = i[5];
            in_valid2 = 1'b1;
            bbv = sub2 ? ~b2 : b2;
            tot = {1'b0, a2} + {1'b0, bbv} + {2'b00, (sub2 ? 1'b1 : cin2)};
            ov  = (a2[1] == bbv[1]) && (tot[1] != a2[1]);
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            @(posedge clk); #1;
            total++;
            if ({out_valid2, cout2, sum2, ovf2, zero2} !== {1'b1, tot, ov, (tot[1:0] == 2'b00)}) begin
                bad++;
                $display("FAIL w2[a=%0d b=%0d cin=%0b sub=%0b] got v=%0b c=%0b s=%0d o=%0b z=%0b exp c=%0b s=%0d o=%0b",
                         a2, b2, cin2, sub2, out_valid2, cout2, sum2, ovf2, zero2, tot[2], tot[1:0], ov);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0; out_ready2 = 1'b1;
        test_reset();
        test_add_basic();
        test_full_carry();
        test_overflow_sub();
        test_back_to_back();
        test_reset_midstream();
        test_exhaustive_w2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
